// File: rtl/edge_detect_mc_pkg.sv
// ---------------------------------------------------------------------------
// edge_detect_mc_pkg
// Shared definitions for the multi-channel edge detector:
//   - mode_t and the four edge-mode encodings (off / rising / falling / both)
//   - DEGLITCH_ENABLED, set by the optional macro EDGE_DETECT_MC_DEGLITCH_EN
//   - startup_threshold(): number of cycles after reset before detections
//     are allowed through (synchroniser depth, plus filter depth when the
//     deglitch filter is built, plus one cycle for the previous-level flop)
// ---------------------------------------------------------------------------
package edge_detect_mc_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_RISE = 2'b01;
  localparam mode_t MODE_FALL = 2'b10;
  localparam mode_t MODE_BOTH = 2'b11;

`ifdef EDGE_DETECT_MC_DEGLITCH_EN
  localparam bit DEGLITCH_ENABLED = 1'b1;
`else
  localparam bit DEGLITCH_ENABLED = 1'b0;
`endif

  function automatic int startup_threshold(input int sync_stages, input int deglitch_len);
    return sync_stages + 1 + (DEGLITCH_ENABLED ? deglitch_len : 0);
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// ---------------------------------------------------------------------------
// edge_det_chan
// One channel of the edge detector: synchroniser, optional deglitch filter
// (macro EDGE_DETECT_MC_DEGLITCH_EN), previous-level register, edge decode,
// registered event pulse, sticky flag and saturating event counter.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   din          raw asynchronous level input
//   mode         edge mode (00 off, 01 rising, 10 falling, 11 both)
//   ready        start-up suppression finished (from top level)
//   sticky_clr   write-1-clear of the sticky flag
//   cnt_clr      synchronous counter clear
//   edge_pulse   one-cycle registered event pulse
//   sticky       latched event flag
//   evt_cnt      saturating event counter
// ---------------------------------------------------------------------------
module edge_det_chan
  import edge_detect_mc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8
`ifdef EDGE_DETECT_MC_DEGLITCH_EN
  ,
  parameter int DEGLITCH_LEN = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             ready,
  input  logic             sticky_clr,
  input  logic             cnt_clr,
  output logic             edge_pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_lvl;
  logic                   w_lvl;
  logic                   r_prev;
  mode_t                  w_mode;
  logic                   w_det;
  logic                   r_pulse;
  logic                   r_sticky;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_mode = mode;

  // Synchroniser shift chain; the last stage is the first usable level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_sync_lvl = r_sync[SYNC_STAGES-1];

`ifdef EDGE_DETECT_MC_DEGLITCH_EN
  localparam int DG_W = (DEGLITCH_LEN < 1) ? 1 : $clog2(DEGLITCH_LEN + 1);

  logic [DG_W-1:0] r_dg_cnt;
  logic            r_flt;

  // Stability filter: a new level is accepted only after it has been seen
  // for DEGLITCH_LEN consecutive cycles; any return to the filtered level
  // restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dg_cnt <= '0;
      r_flt    <= 1'b0;
    end else if (w_sync_lvl == r_flt) begin
      r_dg_cnt <= '0;
    end else if (r_dg_cnt == DG_W'(DEGLITCH_LEN - 1)) begin
      r_dg_cnt <= '0;
      r_flt    <= w_sync_lvl;
    end else begin
      r_dg_cnt <= r_dg_cnt + 1'b1;
    end
  end

  assign w_lvl = r_flt;
`else
  assign w_lvl = w_sync_lvl;
`endif

  // Previous level tracks every cycle, even in MODE_OFF, so a later mode
  // change never sees a stale level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_lvl;
    end
  end

  // Edge decode against the selected mode.
  always_comb begin
    w_det = 1'b0;
    case (w_mode)
      MODE_OFF:  w_det = 1'b0;
      MODE_RISE: w_det = w_lvl & ~r_prev;
      MODE_FALL: w_det = ~w_lvl & r_prev;
      MODE_BOTH: w_det = w_lvl ^ r_prev;
      default:   w_det = 1'b0;
    endcase
  end

  // Event pulse (gated by ready) and sticky flag; a set beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_pulse  <= w_det & ready;
      r_sticky <= r_pulse | (r_sticky & ~sticky_clr);
    end
  end

  // Counter next value: clear with a coincident event yields one, and the
  // count saturates instead of wrapping.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (cnt_clr) begin
      w_cnt_nxt = r_pulse ? CNT_ONE : '0;
    end else if (r_pulse && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign edge_pulse = r_pulse;
  assign sticky     = r_sticky;
  assign evt_cnt    = r_cnt;

endmodule

// File: rtl/edge_detect_mc.sv
// ---------------------------------------------------------------------------
// edge_detect_mc
// Multi-channel edge detector for asynchronous level inputs. Holds the
// start-up suppression counter, the ready flag, the masked interrupt and
// the per-channel bus slicing; each channel is an edge_det_chan instance.
// Optional macro EDGE_DETECT_MC_DEGLITCH_EN adds a per-channel stability
// filter of DEGLITCH_LEN cycles and lengthens start-up suppression to match.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   din          [CH]        raw asynchronous inputs
//   mode         [2*CH]      per-channel edge mode, channel i = [2i+1:2i]
//   sticky_clr   [CH]        write-1-clear of sticky flags
//   cnt_clr                  synchronous clear of all counters
//   irq_mask     [CH]        1 = channel contributes to irq
//   edge_pulse   [CH]        one-cycle pulse per detected edge
//   sticky       [CH]        latched event flags
//   evt_cnt      [CH*CNT_W]  per-channel saturating counters
//   irq                      registered OR of (sticky & irq_mask)
//   ready                    start-up suppression has ended
// ---------------------------------------------------------------------------
module edge_detect_mc
  import edge_detect_mc_pkg::*;
#(
  parameter int CH           = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int CNT_W        = 8,
  parameter int DEGLITCH_LEN = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       din,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       sticky_clr,
  input  logic                cnt_clr,
  input  logic [CH-1:0]       irq_mask,
  output logic [CH-1:0]       edge_pulse,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] evt_cnt,
  output logic                irq,
  output logic                ready
);

  localparam int START_TH = startup_threshold(SYNC_STAGES, DEGLITCH_LEN);
  localparam int START_W  = $clog2(START_TH + 1);

  logic [START_W-1:0] r_start;
  logic [START_W-1:0] w_start_nxt;
  logic               r_ready;
  logic               r_irq;
  logic [CH-1:0]      w_pulse;
  logic [CH-1:0]      w_sticky;

  // Start-up count climbs to the threshold and then holds.
  always_comb begin
    if (r_start == START_W'(START_TH)) begin
      w_start_nxt = r_start;
    end else begin
      w_start_nxt = r_start + 1'b1;
    end
  end

  // Start-up counter and ready; ready rises on the edge the count lands on
  // the threshold, by which time the whole pipeline holds post-reset data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start <= '0;
      r_ready <= 1'b0;
    end else begin
      r_start <= w_start_nxt;
      r_ready <= (w_start_nxt == START_W'(START_TH));
    end
  end

  // Masked interrupt, one cycle behind the sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_sticky & irq_mask);
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .CNT_W        (CNT_W)
`ifdef EDGE_DETECT_MC_DEGLITCH_EN
      ,
      .DEGLITCH_LEN (DEGLITCH_LEN)
`endif
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (din[g]),
      .mode       (mode[2*g +: 2]),
      .ready      (r_ready),
      .sticky_clr (sticky_clr[g]),
      .cnt_clr    (cnt_clr),
      .edge_pulse (w_pulse[g]),
      .sticky     (w_sticky[g]),
      .evt_cnt    (evt_cnt[CNT_W*g +: CNT_W])
    );
  end

  assign edge_pulse = w_pulse;
  assign sticky     = w_sticky;
  assign irq        = r_irq;
  assign ready      = r_ready;

endmodule

// File: tb/tb_edge_detect_mc.sv
// ---------------------------------------------------------------------------
// tb_edge_detect_mc
// Randomised and directed stimulus for edge_detect_mc. A reference model
// works on histories of sampled inputs and derived levels; every clock edge
// it pushes the outputs it expects after that edge into a queue, and an
// independent monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_edge_detect_mc;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 8;
  localparam int DL = 3;
`ifdef EDGE_DETECT_MC_DEGLITCH_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam int TH      = SS + (FILT != 0 ? DL : 0) + 1;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [CH-1:0]     din = '0;
  logic [2*CH-1:0]   mode = '0;
  logic [CH-1:0]     sticky_clr = '0;
  logic              cnt_clr = 1'b0;
  logic [CH-1:0]     irq_mask = '0;
  logic [CH-1:0]     edge_pulse;
  logic [CH-1:0]     sticky;
  logic [CH*CW-1:0]  evt_cnt;
  logic              irq;
  logic              ready;

  edge_detect_mc #(
    .CH           (CH),
    .SYNC_STAGES  (SS),
    .CNT_W        (CW),
    .DEGLITCH_LEN (DL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .mode       (mode),
    .sticky_clr (sticky_clr),
    .cnt_clr    (cnt_clr),
    .irq_mask   (irq_mask),
    .edge_pulse (edge_pulse),
    .sticky     (sticky),
    .evt_cnt    (evt_cnt),
    .irq        (irq),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0]    pulse;
    logic [CH-1:0]    stk;
    logic [CH*CW-1:0] cnt;
    logic             irq;
    logic             rdy;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  logic [CH-1:0] m_din_q[$];   // din sampled at each edge since reset
  logic [CH-1:0] m_sync_q[$];  // synchronised level after each edge
  logic [CH-1:0] m_lvl_q[$];   // level seen by the detector after each edge
  int            m_edges;
  logic [CH-1:0] m_pulse;
  logic [CH-1:0] m_sticky;
  int            m_cnt[CH];
  logic          m_irq;
  logic          m_ready;

  function automatic logic [CH-1:0] back(input logic [CH-1:0] q[$], input int k);
    if (k < q.size()) return q[q.size() - 1 - k];
    return '0;
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t          e;
    logic [CH-1:0] lvl1, lvl2, det, n_pulse, n_sticky, n_sync, n_lvl, hs;
    logic          n_irq, n_ready, rise, fall, allv, v;
    logic [1:0]    md;
    int            n_cnt[CH];
    if (rst) begin
      m_din_q.delete();
      m_sync_q.delete();
      m_lvl_q.delete();
      m_edges  = 0;
      m_pulse  = '0;
      m_sticky = '0;
      m_irq    = 1'b0;
      m_ready  = 1'b0;
      for (int i = 0; i < CH; i++) m_cnt[i] = 0;
      if (clk) begin
        e.pulse = '0; e.stk = '0; e.cnt = '0; e.irq = 1'b0; e.rdy = 1'b0;
        exp_q.push_back(e);
      end else begin
        exp_q.delete();
      end
    end else begin
      lvl1 = back(m_lvl_q, 0);
      lvl2 = back(m_lvl_q, 1);
      for (int i = 0; i < CH; i++) begin
        md     = mode[2*i +: 2];
        rise   = lvl1[i] && !lvl2[i];
        fall   = !lvl1[i] && lvl2[i];
        det[i] = (md == 2'b01 && rise) || (md == 2'b10 && fall) ||
                 (md == 2'b11 && (rise || fall));
      end
      n_pulse  = m_ready ? det : '0;
      n_sticky = m_pulse | (m_sticky & ~sticky_clr);
      for (int i = 0; i < CH; i++) begin
        if (cnt_clr) n_cnt[i] = m_pulse[i] ? 1 : 0;
        else if (m_pulse[i]) n_cnt[i] = (m_cnt[i] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[i] + 1;
        else n_cnt[i] = m_cnt[i];
      end
      n_irq   = |(m_sticky & irq_mask);
      m_edges = m_edges + 1;
      n_ready = (m_edges >= TH);

      m_din_q.push_back(din);
      n_sync = back(m_din_q, SS - 1);
      if (FILT != 0) begin
        // Filtered level flips once the last DL synchronised samples all
        // agree on the opposite value.
        n_lvl = lvl1;
        for (int i = 0; i < CH; i++) begin
          v    = !lvl1[i];
          allv = 1'b1;
          for (int k = 0; k < DL; k++) begin
            hs = back(m_sync_q, k);
            if (hs[i] != v) allv = 1'b0;
          end
          if (allv) n_lvl[i] = v;
        end
      end else begin
        n_lvl = n_sync;
      end
      m_sync_q.push_back(n_sync);
      m_lvl_q.push_back(n_lvl);
      while (m_din_q.size() > 16) void'(m_din_q.pop_front());
      while (m_sync_q.size() > 16) void'(m_sync_q.pop_front());
      while (m_lvl_q.size() > 16) void'(m_lvl_q.pop_front());

      m_pulse  = n_pulse;
      m_sticky = n_sticky;
      m_irq    = n_irq;
      m_ready  = n_ready;
      for (int i = 0; i < CH; i++) m_cnt[i] = n_cnt[i];

      e.pulse = m_pulse;
      e.stk   = m_sticky;
      for (int i = 0; i < CH; i++) e.cnt[CW*i +: CW] = m_cnt[i][CW-1:0];
      e.irq   = m_irq;
      e.rdy   = m_ready;
      exp_q.push_back(e);
    end
  end

  // ---------------- monitor ----------------
  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      cmp("edge_pulse", 64'(edge_pulse), 64'(e.pulse));
      cmp("sticky",     64'(sticky),     64'(e.stk));
      cmp("evt_cnt",    64'(evt_cnt),    64'(e.cnt));
      cmp("irq",        64'(irq),        64'(e.irq));
      cmp("ready",      64'(ready),      64'(e.rdy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic set_mode(input int ch, input logic [1:0] m);
    mode[2*ch +: 2] = m;
  endtask

  initial begin
    // Input 0 high through reset with rising mode: no spurious event.
    rst      = 1'b1;
    din      = 4'b0001;
    mode     = 8'b01010101;
    irq_mask = 4'b1111;
    hold(3);
    rst = 1'b0;
    hold(10);

    // Falling edge on channel 0, then sticky and irq follow.
    set_mode(0, 2'b10);
    din[0] = 1'b0;
    hold(8);

    // Both-edge mode on channel 1, ten transitions four cycles apart.
    set_mode(1, 2'b11);
    for (int t = 0; t < 10; t++) begin
      din[1] = ~din[1];
      hold(4);
    end
    hold(4);

    // Drive channel 1 far past counter saturation.
    for (int t = 0; t < 260; t++) begin
      din[1] = ~din[1];
      hold(4);
    end
    hold(6);

    // Clear held on every cycle: sets must still win, counts land on one.
    set_mode(2, 2'b11);
    sticky_clr = 4'b0100;
    cnt_clr    = 1'b1;
    for (int t = 0; t < 6; t++) begin
      din[2] = ~din[2];
      hold(6);
    end
    sticky_clr = 4'b0000;
    cnt_clr    = 1'b0;
    hold(4);
    sticky_clr = 4'b1111;
    tick();
    sticky_clr = 4'b0000;
    hold(2);

    // Mode off while channel 3 rises, then rising mode with input steady.
    set_mode(3, 2'b00);
    din[3] = 1'b1;
    hold(8);
    set_mode(3, 2'b01);
    hold(8);
    din[3] = 1'b0;
    hold(8);
    din[3] = 1'b1;
    hold(8);

    // Short glitch then a longer pulse on channel 0 in rising mode.
    set_mode(0, 2'b01);
    din[0] = 1'b1;
    hold(2);
    din[0] = 1'b0;
    hold(8);
    din[0] = 1'b1;
    hold(5);
    din[0] = 1'b0;
    hold(10);

    // Random traffic.
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
        sticky_clr[i] = ($urandom_range(0, 7) == 0);
      end
      cnt_clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) mode = 8'($urandom);
      if ($urandom_range(0, 63) == 0) irq_mask = 4'($urandom);
      tick();
    end
    sticky_clr = '0;
    cnt_clr    = 1'b0;

    // Asynchronous reset mid-operation with every input held high.
    din  = 4'b1111;
    mode = 8'b11111111;
    hold(6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    hold(12);
    din = 4'b0000;
    hold(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
